// File: rtl/command_packetizer.sv
// command_packetizer
//   Serialises one {cmd, addr, value} request into a stream of WORD_WIDTH words:
//   cmd, addr, then VALUE_WORDS value words (MS word first unless LITTLE_ENDIAN=1).
//   Downstream handshake is o_dv/i_ready; a word moves only when both are high.
//
//   Optional feature macro: CMD_PKT_CHECKSUM_EN
//     defined   -> one trailing word, XOR of every preceding packet word
//     undefined -> packet is exactly VALUE_WORDS+2 words, no checksum logic
//
//   All outputs are registered. Reset (i_reset) is asynchronous, active high.

module command_packetizer #(
    parameter int WORD_WIDTH    = 8,
    parameter int VALUE_WORDS   = 4,
    parameter int LITTLE_ENDIAN = 0
) (
    input  logic                              clk,
    input  logic                              i_reset,
    input  logic [WORD_WIDTH-1:0]             i_cmd,
    input  logic [WORD_WIDTH-1:0]             i_addr,
    input  logic [WORD_WIDTH*VALUE_WORDS-1:0] i_value,
    input  logic                              i_valid,
    output logic                              o_ready,
    output logic [WORD_WIDTH-1:0]             o_data,
    output logic                              o_dv,
    input  logic                              i_ready,
    output logic                              o_busy
);

`ifdef CMD_PKT_CHECKSUM_EN
    localparam int PKT_LEN = VALUE_WORDS + 3;
`else
    localparam int PKT_LEN = VALUE_WORDS + 2;
`endif
    localparam int VAL_W = WORD_WIDTH * VALUE_WORDS;
    localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

`ifdef CMD_PKT_CHECKSUM_EN
    // XOR of cmd, addr and every value word; word order does not matter for XOR.
    function automatic logic [WORD_WIDTH-1:0] pkt_checksum(
        input logic [WORD_WIDTH-1:0] cmd,
        input logic [WORD_WIDTH-1:0] addr,
        input logic [VAL_W-1:0]      value
    );
        logic [WORD_WIDTH-1:0] acc;
        logic [VAL_W-1:0]      rest;
        acc  = cmd ^ addr;
        rest = value;
        for (int k = 0; k < VALUE_WORDS; k++) begin
            acc  = acc ^ rest[WORD_WIDTH-1:0];
            rest = rest >> WORD_WIDTH;
        end
        return acc;
    endfunction
`endif

    state_t                  state_r, state_s;
    logic [IDX_W-1:0]        idx_r, idx_s, idx_inc_s;
    logic [WORD_WIDTH-1:0]   cmd_r, cmd_s;
    logic [WORD_WIDTH-1:0]   addr_r, addr_s;
    logic [VAL_W-1:0]        value_r, value_s;
    logic [WORD_WIDTH-1:0]   data_r, data_s;
    logic                    dv_r, dv_s;
    logic                    busy_r, busy_s;
    logic                    ready_r, ready_s;

    // Packet laid out as an indexable word table built from the captured request.
    logic [WORD_WIDTH-1:0]   pkt_words_s [PKT_LEN];

    assign pkt_words_s[0] = cmd_r;
    assign pkt_words_s[1] = addr_r;

    for (genvar g = 0; g < VALUE_WORDS; g++) begin : g_value_words
        localparam int SRC = (LITTLE_ENDIAN != 0) ? g : (VALUE_WORDS - 1 - g);
        assign pkt_words_s[g + 2] = value_r[SRC*WORD_WIDTH +: WORD_WIDTH];
    end

`ifdef CMD_PKT_CHECKSUM_EN
    assign pkt_words_s[PKT_LEN-1] = pkt_checksum(cmd_r, addr_r, value_r);
`endif

    assign idx_inc_s = idx_r + IDX_W'(1);

    // Next-state and next-output logic: accept in IDLE, step through words in SEND.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        cmd_s   = cmd_r;
        addr_s  = addr_r;
        value_s = value_r;
        data_s  = data_r;
        dv_s    = dv_r;
        busy_s  = busy_r;
        ready_s = ready_r;

        case (state_r)
            ST_IDLE: begin
                if (i_valid) begin
                    // Word 0 is taken straight from the input since the capture
                    // registers only load on this same edge.
                    state_s = ST_SEND;
                    idx_s   = {IDX_W{1'b0}};
                    cmd_s   = i_cmd;
                    addr_s  = i_addr;
                    value_s = i_value;
                    data_s  = i_cmd;
                    dv_s    = 1'b1;
                    busy_s  = 1'b1;
                    ready_s = 1'b0;
                end else begin
                    data_s  = {WORD_WIDTH{1'b0}};
                    dv_s    = 1'b0;
                    busy_s  = 1'b0;
                    ready_s = 1'b1;
                end
            end
            ST_SEND: begin
                if (i_ready) begin
                    if (idx_r == LAST_IDX) begin
                        // Last word leaves now; a new request waits for IDLE.
                        state_s = ST_IDLE;
                        idx_s   = {IDX_W{1'b0}};
                        data_s  = {WORD_WIDTH{1'b0}};
                        dv_s    = 1'b0;
                        busy_s  = 1'b0;
                        ready_s = 1'b1;
                    end else begin
                        idx_s   = idx_inc_s;
                        data_s  = pkt_words_s[idx_inc_s];
                    end
                end else begin
                    // Stall: hold the presented word and the index.
                    idx_s  = idx_r;
                    data_s = data_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = {IDX_W{1'b0}};
                data_s  = {WORD_WIDTH{1'b0}};
                dv_s    = 1'b0;
                busy_s  = 1'b0;
                ready_s = 1'b1;
            end
        endcase
    end

    // State, index, captured request and registered outputs.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_r <= ST_IDLE;
            idx_r   <= {IDX_W{1'b0}};
            cmd_r   <= {WORD_WIDTH{1'b0}};
            addr_r  <= {WORD_WIDTH{1'b0}};
            value_r <= {VAL_W{1'b0}};
            data_r  <= {WORD_WIDTH{1'b0}};
            dv_r    <= 1'b0;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            cmd_r   <= cmd_s;
            addr_r  <= addr_s;
            value_r <= value_s;
            data_r  <= data_s;
            dv_r    <= dv_s;
            busy_r  <= busy_s;
            ready_r <= ready_s;
        end
    end

    assign o_data  = data_r;
    assign o_dv    = dv_r;
    assign o_busy  = busy_r;
    assign o_ready = ready_r;

endmodule

// File: tb/tb_command_packetizer.sv
// tb_command_packetizer
//   Directed bench for command_packetizer (WORD_WIDTH=8, VALUE_WORDS=4).
//   Two instances share all inputs: dut (MS word first) and dut_le (LS word first).
//   Honours CMD_PKT_CHECKSUM_EN the same way the design does.

module tb_command_packetizer;

`ifdef CMD_PKT_CHECKSUM_EN
    localparam int PKT_LEN = 7;
`else
    localparam int PKT_LEN = 6;
`endif

    logic        clk;
    logic        i_reset;
    logic [7:0]  i_cmd;
    logic [7:0]  i_addr;
    logic [31:0] i_value;
    logic        i_valid;
    logic        i_ready;
    logic        o_ready, o_dv, o_busy;
    logic [7:0]  o_data;
    logic        le_ready, le_dv, le_busy;
    logic [7:0]  le_data;

    int checks = 0;
    int passes = 0;

    // Hand-computed packets; element 6 is the checksum word.
    logic [7:0] pkt_a_be [0:6] = '{8'h01, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h26};
    logic [7:0] pkt_a_le [0:6] = '{8'h01, 8'h05, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h26};
    logic [7:0] pkt_b_be [0:6] = '{8'hA5, 8'h3C, 8'h12, 8'h34, 8'h56, 8'h78, 8'h91};

    command_packetizer #(.WORD_WIDTH(8), .VALUE_WORDS(4), .LITTLE_ENDIAN(0)) dut (
        .clk(clk), .i_reset(i_reset), .i_cmd(i_cmd), .i_addr(i_addr),
        .i_value(i_value), .i_valid(i_valid), .o_ready(o_ready),
        .o_data(o_data), .o_dv(o_dv), .i_ready(i_ready), .o_busy(o_busy)
    );

    command_packetizer #(.WORD_WIDTH(8), .VALUE_WORDS(4), .LITTLE_ENDIAN(1)) dut_le (
        .clk(clk), .i_reset(i_reset), .i_cmd(i_cmd), .i_addr(i_addr),
        .i_value(i_value), .i_valid(i_valid), .o_ready(le_ready),
        .o_data(le_data), .o_dv(le_dv), .i_ready(i_ready), .o_busy(le_busy)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge; all driving and sampling happens there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one edge.
    task automatic request(input logic [7:0] c, input logic [7:0] a, input logic [31:0] v);
        i_cmd   = c;
        i_addr  = a;
        i_value = v;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_cmd   = 8'h00;
        i_addr  = 8'h00;
        i_value = 32'h0;
        tick();
        tick();
        checks++;
        if (o_dv !== 1'b0 || o_busy !== 1'b0 || o_data !== 8'h00) begin
            $display("FAIL reset_hold: dv=%b busy=%b data=%h, expected 0 0 00", o_dv, o_busy, o_data);
        end else passes++;
        i_reset = 1'b0;
        tick();
        checks++;
        if (o_ready !== 1'b1 || o_dv !== 1'b0 || o_busy !== 1'b0) begin
            $display("FAIL reset_release: ready=%b dv=%b busy=%b, expected 1 0 0", o_ready, o_dv, o_busy);
        end else passes++;
        // i_ready alone must not start anything.
        i_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (o_dv !== 1'b0 || o_data !== 8'h00 || o_ready !== 1'b1) begin
            $display("FAIL ready_no_dv: dv=%b data=%h ready=%b, expected 0 00 1", o_dv, o_data, o_ready);
        end else passes++;
    endtask

    task automatic test_big_endian();
        i_ready = 1'b1;
        request(8'h01, 8'h05, 32'hDEADBEEF);
        checks++;
        if (o_ready !== 1'b0 || o_busy !== 1'b1) begin
            $display("FAIL be_flags: ready=%b busy=%b, expected 0 1", o_ready, o_busy);
        end else passes++;
        for (int k = 0; k < PKT_LEN; k++) begin
            checks++;
            if (o_dv !== 1'b1 || o_data !== pkt_a_be[k]) begin
                $display("FAIL be_word%0d: dv=%b data=%h, expected 1 %h", k, o_dv, o_data, pkt_a_be[k]);
            end else passes++;
            tick();
        end
        checks++;
        if (o_dv !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
            $display("FAIL be_end: dv=%b ready=%b busy=%b, expected 0 1 0", o_dv, o_ready, o_busy);
        end else passes++;
    endtask

    task automatic test_little_endian();
        i_ready = 1'b1;
        request(8'h01, 8'h05, 32'hDEADBEEF);
        for (int k = 0; k < PKT_LEN; k++) begin
            checks++;
            if (le_dv !== 1'b1 || le_data !== pkt_a_le[k]) begin
                $display("FAIL le_word%0d: dv=%b data=%h, expected 1 %h", k, le_dv, le_data, pkt_a_le[k]);
            end else passes++;
            tick();
        end
        checks++;
        if (le_dv !== 1'b0 || le_ready !== 1'b1) begin
            $display("FAIL le_end: dv=%b ready=%b, expected 0 1", le_dv, le_ready);
        end else passes++;
    endtask

    task automatic test_stall();
        logic [3:0] pattern;
        int         k;
        int         cyc;
        pattern = 4'b1001;  // bit c%4 gives i_ready: 1,0,0,1,...
        k   = 0;
        cyc = 0;
        i_ready = 1'b1;
        request(8'h01, 8'h05, 32'hDEADBEEF);
        while (k < PKT_LEN && cyc < 64) begin
            checks++;
            if (o_dv !== 1'b1 || o_data !== pkt_a_be[k]) begin
                $display("FAIL stall_word%0d_cyc%0d: dv=%b data=%h, expected 1 %h", k, cyc, o_dv, o_data, pkt_a_be[k]);
            end else passes++;
            i_ready = pattern[cyc % 4];
            tick();
            if (i_ready) k++;
            cyc++;
        end
        checks++;
        if (k !== PKT_LEN || o_dv !== 1'b0 || o_ready !== 1'b1) begin
            $display("FAIL stall_end: words=%0d dv=%b ready=%b, expected %0d 0 1", k, o_dv, o_ready, PKT_LEN);
        end else passes++;
        i_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        i_ready = 1'b1;
        request(8'h01, 8'h05, 32'hDEADBEEF);
        // Second request held high with different data during the whole first packet.
        i_cmd   = 8'hA5;
        i_addr  = 8'h3C;
        i_value = 32'h12345678;
        i_valid = 1'b1;
        for (int k = 0; k < PKT_LEN; k++) begin
            checks++;
            if (o_dv !== 1'b1 || o_data !== pkt_a_be[k]) begin
                $display("FAIL b2b_first%0d: dv=%b data=%h, expected 1 %h", k, o_dv, o_data, pkt_a_be[k]);
            end else passes++;
            tick();
        end
        checks++;
        if (o_dv !== 1'b0 || o_ready !== 1'b1) begin
            $display("FAIL b2b_gap: dv=%b ready=%b, expected 0 1", o_dv, o_ready);
        end else passes++;
        tick();
        i_valid = 1'b0;
        for (int k = 0; k < PKT_LEN; k++) begin
            checks++;
            if (o_dv !== 1'b1 || o_data !== pkt_b_be[k]) begin
                $display("FAIL b2b_second%0d: dv=%b data=%h, expected 1 %h", k, o_dv, o_data, pkt_b_be[k]);
            end else passes++;
            tick();
        end
        checks++;
        if (o_dv !== 1'b0 || o_ready !== 1'b1) begin
            $display("FAIL b2b_end: dv=%b ready=%b, expected 0 1", o_dv, o_ready);
        end else passes++;
    endtask

    task automatic test_reset_mid();
        int extra;
        i_ready = 1'b1;
        request(8'h01, 8'h05, 32'hDEADBEEF);
        tick();
        tick();
        tick();
        checks++;
        if (o_data !== 8'hAD) begin
            $display("FAIL mid_pre: data=%h, expected ad", o_data);
        end else passes++;
        #2;
        i_reset = 1'b1;
        #1;
        checks++;
        if (o_dv !== 1'b0 || o_busy !== 1'b0 || o_data !== 8'h00) begin
            $display("FAIL mid_async: dv=%b busy=%b data=%h, expected 0 0 00", o_dv, o_busy, o_data);
        end else passes++;
        tick();
        i_reset = 1'b0;
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (o_dv !== 1'b0) extra++;
        end
        checks++;
        if (extra !== 0 || o_ready !== 1'b1) begin
            $display("FAIL mid_no_words: extra_dv_cycles=%0d ready=%b, expected 0 1", extra, o_ready);
        end else passes++;
        request(8'h01, 8'h05, 32'hDEADBEEF);
        for (int k = 0; k < PKT_LEN; k++) begin
            checks++;
            if (o_dv !== 1'b1 || o_data !== pkt_a_be[k]) begin
                $display("FAIL mid_restart%0d: dv=%b data=%h, expected 1 %h", k, o_dv, o_data, pkt_a_be[k]);
            end else passes++;
            tick();
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_big_endian();
        test_little_endian();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/command_packetizer.md
COMMAND_PACKETIZER -- requirements
Module: command_packetizer

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8, width of cmd, addr and each output word.
REQ-002 SHALL have parameter VALUE_WORDS, default 4, number of WORD_WIDTH words in value.
REQ-003 SHALL have parameter LITTLE_ENDIAN, default 0: 0 sends value MS word first, 1 sends LS word first.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_cmd  input  WORD_WIDTH  command word of request.
REQ-007 SHALL have port i_addr  input  WORD_WIDTH  address word of request.
REQ-008 SHALL have port i_value  input  WORD_WIDTH*VALUE_WORDS  value field of request.
REQ-009 SHALL have port i_valid  input  1  request present.
REQ-010 SHALL have port o_ready  output  1  block can accept a request.
REQ-011 SHALL have port o_data  output  WORD_WIDTH  current packet word.
REQ-012 SHALL have port o_dv  output  1  o_data valid.
REQ-013 SHALL have port i_ready  input  1  downstream (UART TX FIFO) accepts o_data.
REQ-014 SHALL have port o_busy  output  1  packet in progress.

Function
REQ-015 SHALL be the initiator for the simple command controller: emit packet = cmd, addr, then VALUE_WORDS value words (VALUE_WORDS+2 words base).
REQ-016 SHALL implement FSM IDLE -> SEND -> IDLE.
REQ-017 IDLE: o_ready=1, o_dv=0, o_busy=0; request accepted on edge with i_valid=1, moving to SEND.
REQ-018 SHALL register i_cmd, i_addr, i_value at acceptance; later input changes SHALL not affect the packet.
REQ-019 SEND: o_ready=0, o_busy=1, o_dv=1, o_data = current word; first word on o_data in cycle after acceptance (latency 1).
REQ-020 A word SHALL transfer on an edge with o_dv=1 and i_ready=1; word index then advances by one.
REQ-021 While o_dv=1 and i_ready=0, o_data SHALL hold stable and index SHALL not advance (no word dropped or repeated).
REQ-022 Word index counter SHALL be $clog2(packet length) bits wide, zero at packet start.
REQ-023 LITTLE_ENDIAN=0: value words sent from bits [WORD_WIDTH*VALUE_WORDS-1 -: WORD_WIDTH] downward; LITTLE_ENDIAN=1: from [0 +: WORD_WIDTH] upward. cmd and addr order SHALL be fixed.
REQ-024 On transfer of last word, FSM SHALL return to IDLE; o_dv=0 and o_ready=1 in the next cycle; no accept in the same cycle as last transfer.
REQ-025 i_valid while in SEND SHALL be ignored (not queued).
REQ-026 i_ready=1 with o_dv=0 SHALL have no effect.

Reset
REQ-027 On i_reset=1, immediately and asynchronously: FSM=IDLE, index=0, captured registers=0, o_dv=0, o_busy=0, o_data=0, o_ready=1 (after deassertion).
REQ-028 Reset mid-packet SHALL abandon the packet; no remaining words emitted after reset release.

Configuration
REQ-029 Macro CMD_PKT_CHECKSUM_EN defined: one extra trailing word = XOR of all preceding packet words; packet length VALUE_WORDS+3; FSM returns to IDLE after checksum transfer.
REQ-030 Macro undefined: no checksum logic; packet length VALUE_WORDS+2.

Verification
REQ-031 Reset, i_ready=1, request cmd=0x01 addr=0x05 value=0xDEADBEEF, LITTLE_ENDIAN=0 -> o_data 01,05,DE,AD,BE,EF on 6 consecutive cycles starting 1 cycle after accept; o_ready=1 cycle after last.
REQ-032 Same request, LITTLE_ENDIAN=1 -> 01,05,EF,BE,AD,DE.
REQ-033 i_ready toggled 1,0,0,1,... during packet -> every word appears exactly once, o_data stable across stall cycles.
REQ-034 Second i_valid with different data held throughout SEND -> ignored during SEND, accepted only in IDLE, first packet unchanged.
REQ-035 i_reset pulsed after 3rd word of a packet -> o_dv=0 immediately, no further words, next request starts with cmd word.
REQ-036 With CMD_PKT_CHECKSUM_EN, request 01,05,DEADBEEF -> 7th word 0x01^0x05^0xDE^0xAD^0xBE^0xEF = 0x26.
